cpu_datapath: RTL

Datapath stage directly downstream of the instruction controller FSM in the lab CPU. Holds the instruction register, an 8×16 register file, A/B/C operand registers, the shifter, the ALU and the Z/N/V status register. Executes exactly the per-cycle control word (nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads) the controller drives each clock. Returns opcode/op to the controller for decode.

---
 rtl/cpu_datapath_if.sv | 35 +++
 rtl/cpu_datapath.sv | 112 +++++++++++
 2 files changed

// File: rtl/cpu_datapath_if.sv
// Control word, instruction/data inputs and decode/status outputs exchanged
// between the instruction controller (master) and the datapath (slave).
interface cpu_datapath_if;
    logic        load_ir;
    logic [15:0] in;
    logic [15:0] mdata;
    logic [7:0]  pc;
    logic [2:0]  nsel;
    logic [3:0]  vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [15:0] datapath_out;
    logic        Z;
    logic        N;
    logic        V;

    modport master (
        output load_ir, in, mdata, pc, nsel, vsel, write,
               loada, loadb, loadc, loads, asel, bsel,
        input  opcode, op, datapath_out, Z, N, V
    );

    modport slave (
        input  load_ir, in, mdata, pc, nsel, vsel, write,
               loada, loadb, loadc, loads, asel, bsel,
        output opcode, op, datapath_out, Z, N, V
    );
endinterface

// File: rtl/cpu_datapath.sv
// Lab CPU datapath: instruction register, 8x16 register file, A/B/C operand
// registers, shifter, ALU and Z/N/V status, driven by a per-cycle control word.
module cpu_datapath (
    input  logic           clk,
    input  logic           reset,
    cpu_datapath_if.slave  dp
);
    logic [15:0] ir;
    logic [15:0] regs [8];
    logic [15:0] a, b, c;
    logic        z, n, v;

    logic [2:0]  idx;
    logic [15:0] rdata, wdata;
    logic [15:0] sximm8, sximm5;
    logic [15:0] shout, ain, bin, result;
    logic        ovf;

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // One register index serves both the read port and the write port.
    always_comb begin
        idx = 3'd0;
        case (dp.nsel)
            3'b100:  idx = ir[10:8];
            3'b010:  idx = ir[7:5];
            3'b001:  idx = ir[2:0];
            default: idx = 3'd0;
        endcase
    end

    assign rdata = regs[idx];

    always_comb begin
        wdata = 16'd0;
        case (dp.vsel)
            4'b1000: wdata = dp.mdata;
            4'b0100: wdata = sximm8;
            4'b0010: wdata = {8'd0, dp.pc};
            4'b0001: wdata = c;
            default: wdata = 16'd0;
        endcase
    end

    always_comb begin
        shout = b;
        case (ir[4:3])
            2'b00: shout = b;
            2'b01: shout = {b[14:0], 1'b0};
            2'b10: shout = {1'b0, b[15:1]};
            2'b11: shout = {b[15], b[15:1]};
        endcase
    end

    // Overflow: operands of equal effective sign giving a result of the other sign.
    always_comb begin
        ain    = dp.asel ? 16'd0 : a;
        bin    = dp.bsel ? sximm5 : shout;
        result = 16'd0;
        ovf    = 1'b0;
        case (ir[12:11])
            2'b00: begin
                result = ain + bin;
                ovf    = (ain[15] == bin[15]) && (result[15] != ain[15]);
            end
            2'b01: begin
                result = ain - bin;
                ovf    = (ain[15] != bin[15]) && (result[15] != ain[15]);
            end
            2'b10: result = ain & bin;
            2'b11: result = ~bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (dp.write) begin
            regs[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 16'd0;
            a  <= 16'd0;
            b  <= 16'd0;
            c  <= 16'd0;
            z  <= 1'b0;
            n  <= 1'b0;
            v  <= 1'b0;
        end else begin
            if (dp.load_ir) ir <= dp.in;
            if (dp.loada)   a  <= rdata;
            if (dp.loadb)   b  <= rdata;
            if (dp.loadc)   c  <= result;
            if (dp.loads) begin
                z <= (result == 16'd0);
                n <= result[15];
                v <= ovf;
            end
        end
    end

    assign dp.opcode       = ir[15:13];
    assign dp.op           = ir[12:11];
    assign dp.datapath_out = c;
    assign dp.Z            = z;
    assign dp.N            = n;
    assign dp.V            = v;
endmodule
